// File: rtl/dispatch_buffer_if.sv
// Decode-side and issue-queue-side signal bundle for dispatch_buffer.
// master drives decode data and the queue's free count; slave is the buffer.
interface dispatch_buffer_if #(
   parameter int ELEM_W = 32,
   parameter int IQ_W   = 4
);
   logic [1:0][ELEM_W-1:0] dec_data;
   logic [1:0]             dec_number;
   logic                   dec_ready;
   logic                   dec_err;
   logic [IQ_W-1:0]        size_left;
   logic [1:0][ELEM_W-1:0] in_data;
   logic [1:0]             in_data_number;

   modport master (
      output dec_data, dec_number, size_left,
      input  dec_ready, dec_err, in_data, in_data_number
   );

   modport slave (
      input  dec_data, dec_number, size_left,
      output dec_ready, dec_err, in_data, in_data_number
   );
endinterface

// File: rtl/dispatch_buffer.sv
// Circular buffer between decode and issue_queue: takes up to two instructions
// per cycle from decode and forwards up to two in order, never beyond size_left.
module dispatch_buffer #(
   parameter int BUF_DEPTH = 4,
   parameter int ELEM_W    = 32,
   parameter int IQ_W      = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   output logic [$clog2(BUF_DEPTH):0] occupancy,
   dispatch_buffer_if.slave           bus
);
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ELEM_W-1:0] mem_r [BUF_DEPTH];
   logic [PTR_W-1:0]  rd_r;
   logic [PTR_W-1:0]  wr_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              dec_err_r;

   logic [PTR_W-1:0]  rd1_s;
   logic [PTR_W-1:0]  wr1_s;
   logic [1:0]        pop_s;
   logic [1:0]        acc_s;
   logic              ready_s;
   logic              err_s;

   // Push-out count, accept count and error detection from registered state
   always_comb begin
      pop_s   = 2'd0;
      acc_s   = 2'd0;
      err_s   = 1'b0;
      rd1_s   = rd_r + PTR_W'(1);
      wr1_s   = wr_r + PTR_W'(1);
      ready_s = 1'b0;
      if (flush) begin
         pop_s   = 2'd0;
         ready_s = 1'b0;
      end else begin
         ready_s = (cnt_r <= CNT_W'(BUF_DEPTH - 2));
         if ((cnt_r >= CNT_W'(2)) && (bus.size_left >= IQ_W'(2))) begin
            pop_s = 2'd2;
         end else if ((cnt_r >= CNT_W'(1)) && (bus.size_left >= IQ_W'(1))) begin
            pop_s = 2'd1;
         end else begin
            pop_s = 2'd0;
         end
      end
      if (ready_s) begin
         case (bus.dec_number)
            2'd1:    acc_s = 2'd1;
            2'd2:    acc_s = 2'd2;
            2'd3:    err_s = 1'b1;
            default: acc_s = 2'd0;
         endcase
      end else begin
         acc_s = 2'd0;
      end
   end

   // Output slots; slots beyond the push count stay zero
   always_comb begin
      bus.in_data = '0;
      if (pop_s >= 2'd1) begin
         bus.in_data[0] = mem_r[rd_r];
      end else begin
         bus.in_data[0] = '0;
      end
      if (pop_s == 2'd2) begin
         bus.in_data[1] = mem_r[rd1_s];
      end else begin
         bus.in_data[1] = '0;
      end
   end

   assign bus.in_data_number = pop_s;
   assign bus.dec_ready      = ready_s;
   assign bus.dec_err        = dec_err_r;
   assign occupancy          = cnt_r;

   // Entry storage, slot 0 lands at wr and slot 1 at wr+1
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (acc_s >= 2'd1) begin
            mem_r[wr_r] <= bus.dec_data[0];
         end
         if (acc_s == 2'd2) begin
            mem_r[wr1_s] <= bus.dec_data[1];
         end
      end
   end

   // Pointers, count and the registered error pulse; flush overrides everything
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_r      <= '0;
         wr_r      <= '0;
         cnt_r     <= '0;
         dec_err_r <= 1'b0;
      end else if (flush) begin
         rd_r      <= '0;
         wr_r      <= '0;
         cnt_r     <= '0;
         dec_err_r <= 1'b0;
      end else begin
         rd_r      <= rd_r + PTR_W'(pop_s);
         wr_r      <= wr_r + PTR_W'(acc_s);
         cnt_r     <= cnt_r + CNT_W'(acc_s) - CNT_W'(pop_s);
         dec_err_r <= err_s;
      end
   end
endmodule

// File: tb/tb_dispatch_buffer.sv
// Directed bench for dispatch_buffer: stimulus pushes expected entries into a
// queue, a negedge monitor pops and compares whatever the buffer presents.
module tb_dispatch_buffer;
   logic       clk;
   logic       rst;
   logic       flush;
   logic [2:0] occupancy;
   int         checks;
   int         errors;
   logic [15:0] exp_q [$];

   dispatch_buffer_if #(.ELEM_W(16), .IQ_W(4)) bus ();

   dispatch_buffer #(.BUF_DEPTH(4), .ELEM_W(16), .IQ_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .occupancy (occupancy),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle: drive after the rising edge, return at the falling edge
   task automatic tick(input logic [1:0] dn, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] sl, input logic fl, input logic push);
      @(posedge clk);
      #1;
      bus.dec_number  = dn;
      bus.dec_data[0] = a;
      bus.dec_data[1] = b;
      bus.size_left   = sl;
      flush           = fl;
      if (fl) exp_q.delete();
      if (push) begin
         exp_q.push_back(a);
         if (dn == 2'd2) exp_q.push_back(b);
      end
      @(negedge clk);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin : mon
      int n;
      logic [15:0] e;
      if (rst) begin
         n = int'(bus.in_data_number);
         check("num_within_size_left", 32'(n <= int'(bus.size_left)), 32'd1);
         for (int k = 0; k < 2; k++) begin
            if (k < n) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out: got %0h expected nothing", bus.in_data[k]);
               end else begin
                  e = exp_q.pop_front();
                  check("out_data", 32'(bus.in_data[k]), 32'(e));
               end
            end else begin
               check("unused_slot_zero", 32'(bus.in_data[k]), 32'd0);
            end
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      flush = 1'b0;
      bus.dec_number = 2'd0;
      bus.dec_data = '0;
      bus.size_left = 4'd0;
      #2;
      check("por_num", 32'(bus.in_data_number), 32'd0);
      check("por_ready", 32'(bus.dec_ready), 32'd1);
      check("por_occ", 32'(occupancy), 32'd0);
      check("por_err", 32'(bus.dec_err), 32'd0);
      #10 rst = 1'b1;

      // Mid-stream reset with three entries held
      tick(2'd2, 16'h0A01, 16'h0B01, 4'd0, 1'b0, 1'b1);
      tick(2'd1, 16'h0C01, 16'h0000, 4'd0, 1'b0, 1'b1);
      tick(2'd0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
      check("pre_rst_occ", 32'(occupancy), 32'd3);
      check("pre_rst_ready", 32'(bus.dec_ready), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      #1;
      check("rst_num", 32'(bus.in_data_number), 32'd0);
      check("rst_in_data", 32'(bus.in_data), 32'd0);
      check("rst_ready", 32'(bus.dec_ready), 32'd1);
      check("rst_occ", 32'(occupancy), 32'd0);
      check("rst_err", 32'(bus.dec_err), 32'd0);
      #1 rst = 1'b1;
      tick(2'd2, 16'h00A0, 16'h00B0, 4'd2, 1'b0, 1'b1);
      tick(2'd0, 16'h0000, 16'h0000, 4'd2, 1'b0, 1'b0);
      check("post_rst_num", 32'(bus.in_data_number), 32'd2);
      check("post_rst_occ", 32'(occupancy), 32'd2);
      tick(2'd0, 16'h0000, 16'h0000, 4'd2, 1'b0, 1'b0);
      check("post_rst_drain_occ", 32'(occupancy), 32'd0);

      // Backpressure: fill with size_left 0, then drain one per cycle
      tick(2'd2, 16'h1A00, 16'h1B00, 4'd0, 1'b0, 1'b1);
      tick(2'd2, 16'h1C00, 16'h1D00, 4'd0, 1'b0, 1'b1);
      tick(2'd0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
      check("bp_occ_full", 32'(occupancy), 32'd4);
      check("bp_ready_low", 32'(bus.dec_ready), 32'd0);
      check("bp_num_stall", 32'(bus.in_data_number), 32'd0);
      tick(2'd2, 16'hDEAD, 16'hBEEF, 4'd0, 1'b0, 1'b0);
      check("bp_ignored_ready", 32'(bus.dec_ready), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick(2'd0, 16'h0000, 16'h0000, 4'd1, 1'b0, 1'b0);
         check("bp_single_num", 32'(bus.in_data_number), 32'd1);
         if (i == 2) check("bp_ready_back", 32'(bus.dec_ready), 32'd1);
      end
      tick(2'd0, 16'h0000, 16'h0000, 4'd1, 1'b0, 1'b0);
      check("bp_drained_occ", 32'(occupancy), 32'd0);
      check("bp_drained_num", 32'(bus.in_data_number), 32'd0);

      // Wrap-around: singles staggered so a pair straddles slots 3 and 0
      tick(2'd1, 16'h5001, 16'h0000, 4'd1, 1'b0, 1'b1);
      tick(2'd1, 16'h5002, 16'h0000, 4'd1, 1'b0, 1'b1);
      tick(2'd1, 16'h5003, 16'h0000, 4'd0, 1'b0, 1'b1);
      tick(2'd1, 16'h5004, 16'h0000, 4'd0, 1'b0, 1'b1);
      tick(2'd0, 16'h0000, 16'h0000, 4'd2, 1'b0, 1'b0);
      check("wrap_pair_num", 32'(bus.in_data_number), 32'd2);
      tick(2'd1, 16'h5005, 16'h0000, 4'd1, 1'b0, 1'b1);
      tick(2'd1, 16'h5006, 16'h0000, 4'd1, 1'b0, 1'b1);
      tick(2'd1, 16'h5007, 16'h0000, 4'd1, 1'b0, 1'b1);
      tick(2'd0, 16'h0000, 16'h0000, 4'd1, 1'b0, 1'b0);
      tick(2'd0, 16'h0000, 16'h0000, 4'd1, 1'b0, 1'b0);
      check("wrap_occ", 32'(occupancy), 32'd0);

      // Simultaneous push-out and accept
      tick(2'd2, 16'h7A00, 16'h7B00, 4'd0, 1'b0, 1'b1);
      tick(2'd2, 16'h7E00, 16'h7F00, 4'd2, 1'b0, 1'b1);
      check("sim_num", 32'(bus.in_data_number), 32'd2);
      check("sim_ready", 32'(bus.dec_ready), 32'd1);
      tick(2'd0, 16'h0000, 16'h0000, 4'd2, 1'b0, 1'b0);
      check("sim_occ_stays", 32'(occupancy), 32'd2);
      check("sim_next_num", 32'(bus.in_data_number), 32'd2);
      tick(2'd0, 16'h0000, 16'h0000, 4'd2, 1'b0, 1'b0);
      check("sim_drained", 32'(occupancy), 32'd0);

      // Flush with three entries and a pending decode pair
      tick(2'd2, 16'h9100, 16'h9200, 4'd0, 1'b0, 1'b1);
      tick(2'd1, 16'h9300, 16'h0000, 4'd0, 1'b0, 1'b1);
      tick(2'd2, 16'h9400, 16'h9500, 4'd2, 1'b1, 1'b0);
      check("flush_num", 32'(bus.in_data_number), 32'd0);
      check("flush_ready", 32'(bus.dec_ready), 32'd0);
      check("flush_occ_before", 32'(occupancy), 32'd3);
      tick(2'd0, 16'h0000, 16'h0000, 4'd2, 1'b0, 1'b0);
      check("flush_occ_after", 32'(occupancy), 32'd0);
      check("flush_num_after", 32'(bus.in_data_number), 32'd0);

      // Illegal decode count
      tick(2'd3, 16'hEEEE, 16'hEEEE, 4'd2, 1'b0, 1'b0);
      check("ill_err_same_cycle", 32'(bus.dec_err), 32'd0);
      tick(2'd0, 16'h0000, 16'h0000, 4'd2, 1'b0, 1'b0);
      check("ill_err_pulse", 32'(bus.dec_err), 32'd1);
      check("ill_occ", 32'(occupancy), 32'd0);
      tick(2'd0, 16'h0000, 16'h0000, 4'd2, 1'b0, 1'b0);
      check("ill_err_cleared", 32'(bus.dec_err), 32'd0);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
